egress_ptr_queue: RTL and testbench

- Per-port egress queue directly downstream of the translator.
- Accepts one frame start pointer per cycle when that port's write request is asserted, buffers pointers in arrival order, and presents them to the port's egress reader over a valid/ready handshake.
- When the queue is full, it drops the incoming pointer and reports it so the memory manager can release the frame's buffer.
- The switch top instantiates it NUM_PORTS times: instance k takes write_reqs_o[k] and start_ptrs_o[k].

---
 rtl/egress_ptr_queue_pkg.sv | 17 +
 rtl/egress_ptr_queue.sv | 89 ++++++++
 tb/tb_egress_ptr_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/egress_ptr_queue_pkg.sv
// Shared constants and types for the per-port egress pointer queue.
// The switch top sizes every port instance from these values.
package egress_ptr_queue_pkg;

  localparam int EGQ_ADDR_W     = 12;
  localparam int EGQ_DEPTH      = 16;
  localparam int EGQ_DROP_CNT_W = 16;

  // Encodes the {push, pop} pair that decides each occupancy update.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_POP  = 2'b01,
    OCC_PUSH = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_e;

endpackage

// File: rtl/egress_ptr_queue.sv
// Per-port first-word-fall-through queue of frame start pointers.
// A push that finds the queue full is dropped and reported for buffer release.
module egress_ptr_queue
  import egress_ptr_queue_pkg::*;
#(
  parameter int ADDR_W     = EGQ_ADDR_W,
  parameter int DEPTH      = EGQ_DEPTH,
  parameter int DROP_CNT_W = EGQ_DROP_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         write_req_i,
  input  logic [ADDR_W-1:0]            start_ptr_i,
  output logic                         ptr_valid_o,
  output logic [ADDR_W-1:0]            ptr_o,
  input  logic                         ptr_ready_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         drop_valid_o,
  output logic [ADDR_W-1:0]            drop_ptr_o,
  output logic [DROP_CNT_W-1:0]        drop_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;
  logic              drop;
  occ_op_e           occ_op;

  assign full_o      = (count == CNT_W'(DEPTH));
  assign empty_o     = (count == '0);
  assign count_o     = count;
  assign ptr_valid_o = !empty_o;
  assign ptr_o       = mem[rd_ptr];

  // A full queue still takes a push when the head leaves in the same cycle.
  assign pop    = ptr_valid_o & ptr_ready_i;
  assign push   = write_req_i & (!full_o | pop);
  assign drop   = write_req_i & full_o & !pop;
  assign occ_op = occ_op_e'({push, pop});

  // Storage stage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= start_ptr_i;
    end
  end

  // Control stage: pointers, occupancy and drop reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop_valid_o <= 1'b0;
      drop_ptr_o   <= '0;
      drop_count_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case (occ_op)
        OCC_PUSH: count <= count + CNT_W'(1);
        OCC_POP:  count <= count - CNT_W'(1);
        default:  count <= count;
      endcase
      drop_valid_o <= drop;
      if (drop) begin
        drop_ptr_o   <= start_ptr_i;
        drop_count_o <= sat_inc(drop_count_o);
      end
    end
  end

endmodule

// File: tb/tb_egress_ptr_queue.sv
// Scoreboard bench for egress_ptr_queue: stimulus pushes expectations, a negedge monitor checks.
module tb_egress_ptr_queue;

  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int DCW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_req_i;
  logic [AW-1:0] start_ptr_i;
  logic          ptr_valid_o;
  logic [AW-1:0] ptr_o;
  logic          ptr_ready_i;
  logic          full_o;
  logic          empty_o;
  logic [4:0]    count_o;
  logic          drop_valid_o;
  logic [AW-1:0] drop_ptr_o;
  logic [DCW-1:0] drop_count_o;

  // Small instance used to reach drop counter saturation quickly.
  logic          s_rst;
  logic          s_wr;
  logic [AW-1:0] s_ptr;
  logic          s_valid;
  logic [AW-1:0] s_ptr_o;
  logic          s_rdy;
  logic          s_full;
  logic          s_empty;
  logic [1:0]    s_count;
  logic          s_drop_valid;
  logic [AW-1:0] s_drop_ptr;
  logic [1:0]    s_drop_count;

  always #5 clk = ~clk;

  egress_ptr_queue #(.ADDR_W(AW), .DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
    .clk(clk), .rst(rst), .write_req_i(write_req_i), .start_ptr_i(start_ptr_i),
    .ptr_valid_o(ptr_valid_o), .ptr_o(ptr_o), .ptr_ready_i(ptr_ready_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .drop_valid_o(drop_valid_o), .drop_ptr_o(drop_ptr_o), .drop_count_o(drop_count_o)
  );

  egress_ptr_queue #(.ADDR_W(AW), .DEPTH(2), .DROP_CNT_W(2)) sat_dut (
    .clk(clk), .rst(s_rst), .write_req_i(s_wr), .start_ptr_i(s_ptr),
    .ptr_valid_o(s_valid), .ptr_o(s_ptr_o), .ptr_ready_i(s_rdy),
    .full_o(s_full), .empty_o(s_empty), .count_o(s_count),
    .drop_valid_o(s_drop_valid), .drop_ptr_o(s_drop_ptr), .drop_count_o(s_drop_count)
  );

  int            errors = 0;
  int            checks = 0;
  int            mcnt   = 0;
  int            mdrops = 0;
  bit            mdrop_now = 1'b0;
  bit            armed = 1'b0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] drop_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model once per cycle.
  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("count", 32'(count_o), mcnt);
      chk("empty", 32'(empty_o), 32'(mcnt == 0));
      chk("full", 32'(full_o), 32'(mcnt == DEPTH));
      chk("ptr_valid", 32'(ptr_valid_o), 32'(mcnt != 0));
      if (ptr_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("head_unexpected", 32'(ptr_o), 32'hFFFF_FFFF);
        end else begin
          chk("head", 32'(ptr_o), 32'(exp_q[0]));
          if (ptr_ready_i) void'(exp_q.pop_front());
        end
      end
      chk("drop_valid", 32'(drop_valid_o), 32'(mdrop_now));
      if (drop_valid_o && drop_q.size() != 0) begin
        chk("drop_ptr", 32'(drop_ptr_o), 32'(drop_q.pop_front()));
      end
      chk("drop_count", 32'(drop_count_o), mdrops);
    end
  end

  task automatic step(input logic wr, input logic [AW-1:0] p, input logic rdy);
    bit pp, ps, dr;
    write_req_i = wr;
    start_ptr_i = p;
    ptr_ready_i = rdy;
    pp = (mcnt > 0) && rdy;
    ps = wr && ((mcnt < DEPTH) || pp);
    dr = wr && !ps;
    if (ps) exp_q.push_back(p);
    if (dr) drop_q.push_back(p);
    @(posedge clk);
    #1;
    mcnt = mcnt + int'(ps) - int'(pp);
    mdrop_now = dr;
    if (dr && mdrops != 32'hFFFF) mdrops++;
    write_req_i = 1'b0;
    ptr_ready_i = 1'b0;
  endtask

  task automatic do_reset(input logic wr);
    rst = 1'b1;
    write_req_i = wr;
    start_ptr_i = 12'h7FF;
    ptr_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    write_req_i = 1'b0;
    mcnt = 0;
    mdrops = 0;
    mdrop_now = 1'b0;
    exp_q.delete();
    drop_q.delete();
    armed = 1'b1;
  endtask

  task automatic s_step(input logic wr, input logic [AW-1:0] p);
    s_wr  = wr;
    s_ptr = p;
    @(posedge clk);
    #1;
    s_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_req_i = 1'b0; start_ptr_i = '0; ptr_ready_i = 1'b0;
    s_rst = 1'b1; s_wr = 1'b0; s_ptr = '0; s_rdy = 1'b0;
    @(posedge clk);
    #1;
    s_rst = 1'b0;
    do_reset(1'b0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_valid", 32'(ptr_valid_o), 0);
    chk("rst_drop_valid", 32'(drop_valid_o), 0);
    chk("rst_drop_ptr", 32'(drop_ptr_o), 0);
    chk("rst_drop_count", 32'(drop_count_o), 0);

    // Single push, held head, single pop.
    step(1'b1, 12'h100, 1'b0);
    chk("t1_valid", 32'(ptr_valid_o), 1);
    chk("t1_ptr", 32'(ptr_o), 32'h100);
    chk("t1_count", 32'(count_o), 1);
    chk("t1_empty", 32'(empty_o), 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    chk("t1_hold", 32'(ptr_o), 32'h100);
    step(1'b0, '0, 1'b1);
    chk("t1_pop_count", 32'(count_o), 0);
    chk("t1_pop_valid", 32'(ptr_valid_o), 0);

    // Fill to full.
    for (int i = 0; i < 16; i++) step(1'b1, 12'(32'h200 + i), 1'b0);
    chk("t2_full", 32'(full_o), 1);
    chk("t2_count", 32'(count_o), 16);

    // Drop while full.
    step(1'b1, 12'h300, 1'b0);
    chk("t3_drop_valid", 32'(drop_valid_o), 1);
    chk("t3_drop_ptr", 32'(drop_ptr_o), 32'h300);
    chk("t3_drop_count", 32'(drop_count_o), 1);
    chk("t3_count", 32'(count_o), 16);
    chk("t3_head", 32'(ptr_o), 32'h200);
    step(1'b0, '0, 1'b0);
    chk("t3_drop_pulse", 32'(drop_valid_o), 0);

    // Push and pop together while full, then drain: 0x201..0x20F then 0x400.
    step(1'b1, 12'h400, 1'b1);
    chk("t4_no_drop", 32'(drop_valid_o), 0);
    chk("t4_count", 32'(count_o), 16);
    chk("t4_head", 32'(ptr_o), 32'h201);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
    chk("t4_tail", 32'(ptr_o), 32'h400);
    step(1'b0, '0, 1'b1);
    chk("t4_empty", 32'(empty_o), 1);
    chk("t4_sb_empty", 32'(exp_q.size()), 0);

    // Mixed traffic with random ready.
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 3) != 0), 12'(32'h500 + i), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    chk("t5_sb_empty", 32'(exp_q.size()), 0);

    // Back-to-back drops each carry their own pointer.
    for (int i = 0; i < 16; i++) step(1'b1, 12'(32'h580 + i), 1'b0);
    step(1'b1, 12'h600, 1'b0);
    chk("t5_drop_a", 32'(drop_ptr_o), 32'h600);
    step(1'b1, 12'h601, 1'b0);
    chk("t5_drop_b_valid", 32'(drop_valid_o), 1);
    chk("t5_drop_b", 32'(drop_ptr_o), 32'h601);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);

    // Reset with five entries queued and a push request pending.
    for (int i = 0; i < 5; i++) step(1'b1, 12'(32'h700 + i), 1'b0);
    do_reset(1'b1);
    chk("t6_count", 32'(count_o), 0);
    chk("t6_valid", 32'(ptr_valid_o), 0);
    chk("t6_drop_valid", 32'(drop_valid_o), 0);
    chk("t6_drop_count", 32'(drop_count_o), 0);
    step(1'b0, '0, 1'b1);

    // Saturation on the 2-bit drop counter of the depth-2 instance.
    s_step(1'b1, 12'h001);
    s_step(1'b1, 12'h002);
    chk("sat_full", 32'(s_full), 1);
    for (int k = 0; k < 5; k++) begin
      s_step(1'b1, 12'(32'h010 + k));
      chk("sat_drop_valid", 32'(s_drop_valid), 1);
      chk("sat_drop_ptr", 32'(s_drop_ptr), 32'h010 + k);
      chk("sat_drop_count", 32'(s_drop_count), (k < 3) ? k + 1 : 3);
    end
    chk("sat_head", 32'(s_ptr_o), 32'h001);
    s_rst = 1'b1;
    @(posedge clk);
    #1;
    s_rst = 1'b0;
    chk("sat_rst_count", 32'(s_drop_count), 0);
    chk("sat_rst_empty", 32'(s_empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
